// File: rtl/dfi_set_walker.sv
// Definition-set walker: runtime-loaded pointer and data tables, a cursor that
// steps through one set, and a per-check compare of observed (addr, data).
module dfi_set_walker #(
    parameter int ADDR_W     = 32,
    parameter int PTR_LINES  = 16,
    parameter int PTR_IDX_W  = 4,
    parameter int DATA_LINES = 64,
    parameter int DATA_IDX_W = 6,
    parameter int WRAP_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_cfg_we,
    input  logic                  i_cfg_sel,
    input  logic [DATA_IDX_W-1:0] i_cfg_idx,
    input  logic [3*ADDR_W-1:0]   i_cfg_wdata,
    output logic                  o_cfg_ack,
    input  logic                  i_start,
    input  logic [PTR_IDX_W-1:0]  i_set_idx,
    input  logic                  i_chk_valid,
    input  logic [ADDR_W-1:0]     i_chk_addr,
    input  logic [ADDR_W-1:0]     i_chk_data,
    output logic                  o_chk_ready,
    output logic                  o_rsp_valid,
    output logic                  o_rsp_ok,
    output logic [DATA_IDX_W-1:0] o_cur_ptr,
    output logic                  o_busy,
    output logic                  o_err,
    output logic [2:0]            o_err_code
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_RANGE = 3'd1;
    localparam logic [2:0] E_EMPTY = 3'd2;
    localparam logic [2:0] E_ADDR  = 3'd3;
    localparam logic [2:0] E_DATA  = 3'd4;
    localparam logic [2:0] E_EXH   = 3'd5;

    localparam logic [DATA_IDX_W:0] DATA_LIM = (DATA_IDX_W+1)'(DATA_LINES);
    localparam logic [DATA_IDX_W:0] PTR_LIM_C = (DATA_IDX_W+1)'(PTR_LINES);
    localparam logic [PTR_IDX_W:0]  PTR_LIM_S = (PTR_IDX_W+1)'(PTR_LINES);

    logic [DATA_IDX_W-1:0] ptr_base_r [PTR_LINES];
    logic [DATA_IDX_W:0]   ptr_cnt_r  [PTR_LINES];
    logic [ADDR_W-1:0]     dat_addr_r [DATA_LINES];
    logic [ADDR_W-1:0]     dat_lo_r   [DATA_LINES];
    logic [ADDR_W-1:0]     dat_hi_r   [DATA_LINES];

    logic [2:0]            state_r;
    logic [2:0]            state_nxt_s;
    logic [PTR_IDX_W-1:0]  set_idx_r;
    logic [DATA_IDX_W-1:0] cursor_r;
    logic [DATA_IDX_W-1:0] base_r;
    logic [DATA_IDX_W-1:0] end_r;
    logic                  exhausted_r;
    logic [2:0]            pend_code_r;
    logic                  rsp_ok_r;
    logic                  rsp_valid_r;
    logic                  chk_ready_r;
    logic                  busy_r;
    logic                  cfg_ack_r;
    logic                  err_r;
    logic [2:0]            err_code_r;

    logic                  cfg_in_range_s;
    logic                  cfg_wr_s;
    logic                  set_ok_s;
    logic [PTR_IDX_W-1:0]  set_safe_s;
    logic [DATA_IDX_W-1:0] ld_base_s;
    logic [DATA_IDX_W:0]   ld_cnt_s;
    logic [DATA_IDX_W:0]   ld_sum_s;
    logic [DATA_IDX_W-1:0] ld_end_s;
    logic [2:0]            ld_code_s;
    logic                  chk_accept_s;
    logic                  addr_hit_s;
    logic                  data_in_s;
    logic [2:0]            chk_code_s;

    // Write-index range check for whichever table is being addressed.
    always_comb begin
        cfg_in_range_s = 1'b0;
        if (i_cfg_sel) begin
            cfg_in_range_s = ({1'b0, i_cfg_idx} < DATA_LIM);
        end else begin
            cfg_in_range_s = ({1'b0, i_cfg_idx} < PTR_LIM_C);
        end
    end

    assign cfg_wr_s     = (state_r == S_IDLE) && i_cfg_we && cfg_in_range_s && !i_clr;
    assign set_ok_s     = ({1'b0, set_idx_r} < PTR_LIM_S);
    assign set_safe_s   = set_ok_s ? set_idx_r : {PTR_IDX_W{1'b0}};
    assign ld_base_s    = ptr_base_r[set_safe_s];
    assign ld_cnt_s     = ptr_cnt_r[set_safe_s];
    // Sum kept one bit wider than an index so base+count==DATA_LINES is legal.
    assign ld_sum_s     = {1'b0, ld_base_s} + ld_cnt_s;
    assign ld_end_s     = ld_base_s + ld_cnt_s[DATA_IDX_W-1:0] - DATA_IDX_W'(1'b1);
    assign chk_accept_s = (state_r == S_ARMED) && i_chk_valid;
    assign addr_hit_s   = (i_chk_addr == dat_addr_r[cursor_r]);
    assign data_in_s    = (i_chk_data >= dat_lo_r[cursor_r]) && (i_chk_data <= dat_hi_r[cursor_r]);

    // Validate the selected set before arming.
    always_comb begin
        ld_code_s = E_NONE;
        if (!set_ok_s) begin
            ld_code_s = E_RANGE;
        end else if (ld_cnt_s == {(DATA_IDX_W+1){1'b0}}) begin
            ld_code_s = E_EMPTY;
        end else if (ld_sum_s > DATA_LIM) begin
            ld_code_s = E_RANGE;
        end else begin
            ld_code_s = E_NONE;
        end
    end

    // Check verdict; address mismatch outranks data range.
    always_comb begin
        chk_code_s = E_NONE;
        if (exhausted_r) begin
            chk_code_s = E_EXH;
        end else if (!addr_hit_s) begin
            chk_code_s = E_ADDR;
        end else if (!data_in_s) begin
            chk_code_s = E_DATA;
        end else begin
            chk_code_s = E_NONE;
        end
    end

    // Next-state logic; clear wins over everything.
    always_comb begin
        state_nxt_s = state_r;
        if (i_clr) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:  state_nxt_s = i_start ? S_LOAD : S_IDLE;
                S_LOAD:  state_nxt_s = (ld_code_s != E_NONE) ? S_ERR : S_ARMED;
                S_ARMED: state_nxt_s = chk_accept_s ? S_CHECK : S_ARMED;
                S_CHECK: state_nxt_s = (pend_code_r != E_NONE) ? S_ERR : S_ARMED;
                S_ERR:   state_nxt_s = S_ERR;
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Pointer and data table storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PTR_LINES; i++) begin
                ptr_base_r[i] <= {DATA_IDX_W{1'b0}};
                ptr_cnt_r[i]  <= {(DATA_IDX_W+1){1'b0}};
            end
            for (int i = 0; i < DATA_LINES; i++) begin
                dat_addr_r[i] <= {ADDR_W{1'b0}};
                dat_lo_r[i]   <= {ADDR_W{1'b0}};
                dat_hi_r[i]   <= {ADDR_W{1'b0}};
            end
        end else if (cfg_wr_s) begin
            if (i_cfg_sel) begin
                dat_addr_r[i_cfg_idx] <= i_cfg_wdata[3*ADDR_W-1:2*ADDR_W];
                dat_lo_r[i_cfg_idx]   <= i_cfg_wdata[2*ADDR_W-1:ADDR_W];
                dat_hi_r[i_cfg_idx]   <= i_cfg_wdata[ADDR_W-1:0];
            end else begin
                ptr_base_r[i_cfg_idx[PTR_IDX_W-1:0]] <= i_cfg_wdata[DATA_IDX_W-1:0];
                ptr_cnt_r[i_cfg_idx[PTR_IDX_W-1:0]]  <= i_cfg_wdata[2*DATA_IDX_W:DATA_IDX_W];
            end
        end
    end

    // Walk control, cursor bookkeeping and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            set_idx_r   <= {PTR_IDX_W{1'b0}};
            cursor_r    <= {DATA_IDX_W{1'b0}};
            base_r      <= {DATA_IDX_W{1'b0}};
            end_r       <= {DATA_IDX_W{1'b0}};
            exhausted_r <= 1'b0;
            pend_code_r <= E_NONE;
            rsp_ok_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            chk_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            cfg_ack_r   <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= E_NONE;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != S_IDLE);
            chk_ready_r <= (state_nxt_s == S_ARMED);
            rsp_valid_r <= (state_nxt_s == S_CHECK);
            cfg_ack_r   <= cfg_wr_s;
            if (i_clr) begin
                err_r       <= 1'b0;
                err_code_r  <= E_NONE;
                exhausted_r <= 1'b0;
                rsp_ok_r    <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (i_start) begin
                            set_idx_r <= i_set_idx;
                        end
                    end
                    S_LOAD: begin
                        if (ld_code_s != E_NONE) begin
                            err_r      <= 1'b1;
                            err_code_r <= ld_code_s;
                        end else begin
                            cursor_r    <= ld_base_s;
                            base_r      <= ld_base_s;
                            end_r       <= ld_end_s;
                            exhausted_r <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (chk_accept_s) begin
                            pend_code_r <= chk_code_s;
                            rsp_ok_r    <= (chk_code_s == E_NONE);
                        end
                    end
                    S_CHECK: begin
                        rsp_ok_r <= 1'b0;
                        if (pend_code_r != E_NONE) begin
                            err_r      <= 1'b1;
                            err_code_r <= pend_code_r;
                        end else if (cursor_r != end_r) begin
                            cursor_r <= cursor_r + DATA_IDX_W'(1'b1);
                        end else if (WRAP_MODE == 32'sd1) begin
                            cursor_r <= base_r;
                        end else begin
                            exhausted_r <= 1'b1;
                        end
                    end
                    S_ERR: begin
                        err_r <= 1'b1;
                    end
                    default: begin
                        err_r <= err_r;
                    end
                endcase
            end
        end
    end

    assign o_cfg_ack   = cfg_ack_r;
    assign o_chk_ready = chk_ready_r;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_ok    = rsp_ok_r;
    assign o_cur_ptr   = cursor_r;
    assign o_busy      = busy_r;
    assign o_err       = err_r;
    assign o_err_code  = err_code_r;

endmodule

// File: tb/tb_dfi_set_walker.sv
// Bench for dfi_set_walker: a non-wrapping and a wrapping instance share stimulus
// and are checked every cycle against a table/phase model plus literal expectations.
module tb_dfi_set_walker;
    localparam int PL = 12;
    localparam int DL = 64;
    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_ARMED = 2;
    localparam int PH_CHECK = 3;
    localparam int PH_ERR   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, cfg_we, cfg_sel, start, chk_valid;
    logic [5:0]  cfg_idx;
    logic [95:0] cfg_wdata;
    logic [3:0]  set_idx;
    logic [31:0] chk_addr, chk_data;

    logic [1:0]      cfg_ack, chk_ready, rsp_valid, rsp_ok, busy, err;
    logic [1:0][5:0] cur_ptr;
    logic [1:0][2:0] err_code;

    int errors = 0;
    int checks = 0;

    dfi_set_walker #(.PTR_LINES(PL), .WRAP_MODE(0)) u0 (
        .clk(clk), .rst(rst), .i_clr(clr), .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel),
        .i_cfg_idx(cfg_idx), .i_cfg_wdata(cfg_wdata), .o_cfg_ack(cfg_ack[0]),
        .i_start(start), .i_set_idx(set_idx), .i_chk_valid(chk_valid),
        .i_chk_addr(chk_addr), .i_chk_data(chk_data), .o_chk_ready(chk_ready[0]),
        .o_rsp_valid(rsp_valid[0]), .o_rsp_ok(rsp_ok[0]), .o_cur_ptr(cur_ptr[0]),
        .o_busy(busy[0]), .o_err(err[0]), .o_err_code(err_code[0]));

    dfi_set_walker #(.PTR_LINES(PL), .WRAP_MODE(1)) u1 (
        .clk(clk), .rst(rst), .i_clr(clr), .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel),
        .i_cfg_idx(cfg_idx), .i_cfg_wdata(cfg_wdata), .o_cfg_ack(cfg_ack[1]),
        .i_start(start), .i_set_idx(set_idx), .i_chk_valid(chk_valid),
        .i_chk_addr(chk_addr), .i_chk_data(chk_data), .o_chk_ready(chk_ready[1]),
        .o_rsp_valid(rsp_valid[1]), .o_rsp_ok(rsp_ok[1]), .o_cur_ptr(cur_ptr[1]),
        .o_busy(busy[1]), .o_err(err[1]), .o_err_code(err_code[1]));

    // Model: instance 0 exhausts at the end of a set, instance 1 wraps.
    int          m_ph [2], m_set [2], m_cur [2], m_base [2], m_endp [2], m_code [2], m_pend [2];
    bit          m_err [2], m_ok [2], m_ack [2], m_exh [2];
    int          m_pbase [2][16], m_pcnt [2][16];
    logic [31:0] m_daddr [2][64], m_dlo [2][64], m_dhi [2][64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int w);
        m_ph[w] = PH_IDLE; m_set[w] = 0; m_cur[w] = 0; m_base[w] = 0; m_endp[w] = 0;
        m_code[w] = 0; m_pend[w] = 0; m_err[w] = 0; m_ok[w] = 0; m_ack[w] = 0; m_exh[w] = 0;
        for (int i = 0; i < 16; i++) begin
            m_pbase[w][i] = 0;
            m_pcnt[w][i] = 0;
        end
        for (int i = 0; i < 64; i++) begin
            m_daddr[w][i] = 32'd0;
            m_dlo[w][i] = 32'd0;
            m_dhi[w][i] = 32'd0;
        end
    endtask

    task automatic model_fail(input int w, input int code);
        m_ph[w] = PH_ERR;
        m_err[w] = 1'b1;
        m_code[w] = code;
    endtask

    // Advance the model by one clock edge using the inputs presently driven.
    task automatic model_step();
        for (int w = 0; w < 2; w++) begin
            if (rst) begin
                model_reset(w);
            end else if (clr) begin
                m_ph[w] = PH_IDLE; m_err[w] = 0; m_code[w] = 0; m_ack[w] = 0; m_ok[w] = 0; m_exh[w] = 0;
            end else begin
                m_ack[w] = 1'b0;
                case (m_ph[w])
                    PH_IDLE: begin
                        if (cfg_we && cfg_sel && int'(cfg_idx) < DL) begin
                            m_daddr[w][cfg_idx] = cfg_wdata[95:64];
                            m_dlo[w][cfg_idx] = cfg_wdata[63:32];
                            m_dhi[w][cfg_idx] = cfg_wdata[31:0];
                            m_ack[w] = 1'b1;
                        end else if (cfg_we && !cfg_sel && int'(cfg_idx) < PL) begin
                            m_pbase[w][cfg_idx] = int'(cfg_wdata[5:0]);
                            m_pcnt[w][cfg_idx] = int'(cfg_wdata[12:6]);
                            m_ack[w] = 1'b1;
                        end
                        if (start) begin
                            m_set[w] = int'(set_idx);
                            m_ph[w] = PH_LOAD;
                        end
                    end
                    PH_LOAD: begin
                        if (m_set[w] >= PL) model_fail(w, 1);
                        else if (m_pcnt[w][m_set[w]] == 0) model_fail(w, 2);
                        else if (m_pbase[w][m_set[w]] + m_pcnt[w][m_set[w]] > DL) model_fail(w, 1);
                        else begin
                            m_base[w] = m_pbase[w][m_set[w]];
                            m_cur[w] = m_base[w];
                            m_endp[w] = m_base[w] + m_pcnt[w][m_set[w]] - 1;
                            m_exh[w] = 1'b0;
                            m_ph[w] = PH_ARMED;
                        end
                    end
                    PH_ARMED: begin
                        if (chk_valid) begin
                            if (m_exh[w]) m_pend[w] = 5;
                            else if (chk_addr != m_daddr[w][m_cur[w]]) m_pend[w] = 3;
                            else if (chk_data < m_dlo[w][m_cur[w]] || chk_data > m_dhi[w][m_cur[w]]) m_pend[w] = 4;
                            else m_pend[w] = 0;
                            m_ok[w] = (m_pend[w] == 0);
                            m_ph[w] = PH_CHECK;
                        end
                    end
                    PH_CHECK: begin
                        m_ok[w] = 1'b0;
                        if (m_pend[w] != 0) model_fail(w, m_pend[w]);
                        else begin
                            if (m_cur[w] < m_endp[w]) m_cur[w] = m_cur[w] + 1;
                            else if (w == 1) m_cur[w] = m_base[w];
                            else m_exh[w] = 1'b1;
                            m_ph[w] = PH_ARMED;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            check($sformatf("u%0d busy", w), busy[w], m_ph[w] != PH_IDLE);
            check($sformatf("u%0d chk_ready", w), chk_ready[w], m_ph[w] == PH_ARMED);
            check($sformatf("u%0d rsp_valid", w), rsp_valid[w], m_ph[w] == PH_CHECK);
            if (m_ph[w] == PH_CHECK) check($sformatf("u%0d rsp_ok", w), rsp_ok[w], m_ok[w]);
            check($sformatf("u%0d err", w), err[w], m_err[w]);
            check($sformatf("u%0d err_code", w), err_code[w], 64'(m_code[w]));
            check($sformatf("u%0d cur_ptr", w), cur_ptr[w], 64'(m_cur[w]));
            check($sformatf("u%0d cfg_ack", w), cfg_ack[w], m_ack[w]);
        end
    end

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic sel, input logic [5:0] idx, input logic [95:0] wd, input logic [1:0] exp_ack);
        cfg_we = 1'b1; cfg_sel = sel; cfg_idx = idx; cfg_wdata = wd;
        tick();
        cfg_we = 1'b0;
        check("cfg_ack pulse", cfg_ack, exp_ack);
    endtask

    task automatic start_walk(input logic [3:0] s);
        start = 1'b1; set_idx = s;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic send_chk(input logic [31:0] a, input logic [31:0] d, input logic [1:0] exp_ok);
        chk_valid = 1'b1; chk_addr = a; chk_data = d;
        tick();
        chk_valid = 1'b0;
        check("rsp_valid pulse", rsp_valid, 2'b11);
        check("rsp_ok", rsp_ok, exp_ok);
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr err", err, 2'b00);
        check("clr busy", busy, 2'b00);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; start = 1'b0; chk_valid = 1'b0;
        cfg_idx = 6'd0; cfg_wdata = 96'd0; set_idx = 4'd0; chk_addr = 32'd0; chk_data = 32'd0;
        model_reset(0);
        model_reset(1);
        tick();
        tick();
        check("reset busy", busy, 2'b00);
        check("reset cur_ptr", cur_ptr, 12'd0);
        rst = 1'b0;
        tick();

        cfg_wr(1'b0, 6'd2, {83'd0, 7'd3, 6'd5}, 2'b11);
        cfg_wr(1'b1, 6'd5, {32'h1000, 32'h10, 32'h20}, 2'b11);
        cfg_wr(1'b1, 6'd6, {32'h2000, 32'h0, 32'hFF}, 2'b11);
        cfg_wr(1'b1, 6'd7, {32'h3000, 32'h100, 32'h100}, 2'b11);
        cfg_wr(1'b0, 6'd4, {83'd0, 7'd5, 6'd60}, 2'b11);
        cfg_wr(1'b0, 6'd12, {83'd0, 7'd1, 6'd0}, 2'b00);

        start_walk(4'd2);
        check("armed ready", chk_ready, 2'b11);
        check("armed cur 5", cur_ptr, {6'd5, 6'd5});
        send_chk(32'h1000, 32'h15, 2'b11);
        check("cur 6", cur_ptr, {6'd6, 6'd6});
        send_chk(32'h2000, 32'hFF, 2'b11);
        check("cur 7", cur_ptr, {6'd7, 6'd7});
        send_chk(32'h3000, 32'h100, 2'b11);
        check("end exh/wrap", cur_ptr, {6'd5, 6'd7});
        cfg_wr(1'b1, 6'd5, {32'h9999, 32'h0, 32'h0}, 2'b00);
        send_chk(32'h1000, 32'h15, 2'b10);
        check("exhausted err", err, 2'b01);
        check("exhausted code", err_code, {3'd0, 3'd5});
        check("wrap cur 6", cur_ptr[1], 6'd6);
        start = 1'b1; set_idx = 4'd2;
        tick();
        start = 1'b0;
        check("start ignored in err", err_code[0], 3'd5);
        do_clr();
        check("clr code", err_code, 6'd0);

        start_walk(4'd2);
        send_chk(32'h1000, 32'h21, 2'b00);
        check("data range code", err_code, {3'd4, 3'd4});
        do_clr();
        start_walk(4'd2);
        send_chk(32'h1004, 32'h15, 2'b00);
        check("addr code", err_code, {3'd3, 3'd3});
        do_clr();
        start_walk(4'd2);
        send_chk(32'h1004, 32'h21, 2'b00);
        check("addr priority", err_code, {3'd3, 3'd3});
        do_clr();
        start_walk(4'd2);
        send_chk(32'h1000, 32'h20, 2'b11);
        send_chk(32'h2000, 32'h0, 2'b11);
        send_chk(32'h3000, 32'h100, 2'b11);
        do_clr();

        start_walk(4'd15);
        check("set idx range", err_code, {3'd1, 3'd1});
        do_clr();
        start_walk(4'd3);
        check("empty set", err_code, {3'd2, 3'd2});
        do_clr();
        start_walk(4'd4);
        check("table overrun", err_code, {3'd1, 3'd1});
        do_clr();

        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 6'd8; cfg_wdata = {83'd0, 7'd1, 6'd63};
        start = 1'b1; set_idx = 4'd8;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        check("write+start ack", cfg_ack, 2'b11);
        tick();
        check("write+start cur", cur_ptr, {6'd63, 6'd63});
        send_chk(32'h0, 32'h0, 2'b11);
        send_chk(32'h0, 32'h0, 2'b10);
        do_clr();

        start_walk(4'd2);
        chk_valid = 1'b1; chk_addr = 32'h1000; chk_data = 32'h15;
        tick();
        chk_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async rst busy", busy, 2'b00);
        check("async rst rsp_valid", rsp_valid, 2'b00);
        check("async rst cur", cur_ptr, 12'd0);
        check("async rst ready", chk_ready, 2'b00);
        model_reset(0);
        model_reset(1);
        tick();
        rst = 1'b0;
        tick();
        start_walk(4'd2);
        check("post-reset empty", err_code, {3'd2, 3'd2});
        do_clr();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
